// File: rtl/clk_gate_ctrl_fg.sv
// Per-lane clock-gater enable sequencer: round-robin wake arbitration (one lane
// per cycle), warm-up window before ready, idle hysteresis before gating.
module clk_gate_ctrl_fg #(
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned WAKE_CYCLES = 2,
  parameter int unsigned IDLE_CYCLES = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [NUM_LANES-1:0] laneReq_i,
  input  logic [NUM_LANES-1:0] laneDisable_i,
  input  logic                 forceOn_i,
  output logic [NUM_LANES-1:0] clkEn_o,
  output logic [NUM_LANES-1:0] laneRdy_o,
  output logic                 wakePending_o
);

  localparam int unsigned MAX_CYC = (WAKE_CYCLES > IDLE_CYCLES) ? WAKE_CYCLES : IDLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);
  localparam int unsigned PTR_W   = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    LANE_OFF  = 2'd0,
    LANE_WAKE = 2'd1,
    LANE_ON   = 2'd2
  } lane_state_t;

  lane_state_t              state [NUM_LANES];
  logic [CNT_W-1:0]         cnt   [NUM_LANES];
  logic [PTR_W-1:0]         rr_ptr;

  logic [NUM_LANES-1:0]     eff_req;
  logic [NUM_LANES-1:0]     cand;
  logic [NUM_LANES-1:0]     grant;
  logic [PTR_W-1:0]         winner;
  logic [PTR_W-1:0]         arb_idx;
  logic                     found;
  logic                     multi_cand;

  always_comb begin
    eff_req = (laneReq_i | {NUM_LANES{forceOn_i}}) & ~laneDisable_i;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      cand[i] = (state[i] == LANE_OFF) && eff_req[i];
    end
    // Clearing the lowest set bit leaves something only if two or more lanes compete.
    multi_cand = |(cand & (cand - NUM_LANES'(1)));
  end

  // Round-robin search starting at rr_ptr; first OFF requester wins.
  always_comb begin
    grant   = '0;
    winner  = '0;
    arb_idx = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      arb_idx = PTR_W'((32'(rr_ptr) + k) % NUM_LANES);
      if (!found && cand[arb_idx]) begin
        found         = 1'b1;
        grant[arb_idx] = 1'b1;
        winner        = arb_idx;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_ptr        <= '0;
      wakePending_o <= 1'b0;
      clkEn_o       <= '0;
      laneRdy_o     <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        state[i] <= LANE_OFF;
        cnt[i]   <= '0;
      end
    end else begin
      wakePending_o <= multi_cand;
      if (found) begin
        rr_ptr <= PTR_W'((32'(winner) + 1) % NUM_LANES);
      end
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        case (state[i])
          LANE_OFF: begin
            cnt[i] <= '0;
            if (grant[i]) begin
              state[i]     <= LANE_WAKE;
              clkEn_o[i]   <= 1'b1;
              laneRdy_o[i] <= 1'b0;
            end else begin
              clkEn_o[i]   <= 1'b0;
              laneRdy_o[i] <= 1'b0;
            end
          end
          // Requests are ignored during warm-up; only a disable aborts it.
          LANE_WAKE: begin
            if (laneDisable_i[i]) begin
              state[i]     <= LANE_OFF;
              cnt[i]       <= '0;
              clkEn_o[i]   <= 1'b0;
              laneRdy_o[i] <= 1'b0;
            end else if (cnt[i] == CNT_W'(WAKE_CYCLES - 1)) begin
              state[i]     <= LANE_ON;
              cnt[i]       <= '0;
              clkEn_o[i]   <= 1'b1;
              laneRdy_o[i] <= 1'b1;
            end else begin
              cnt[i]       <= cnt[i] + CNT_W'(1);
              clkEn_o[i]   <= 1'b1;
              laneRdy_o[i] <= 1'b0;
            end
          end
          LANE_ON: begin
            if (laneDisable_i[i] ||
                (!eff_req[i] && cnt[i] == CNT_W'(IDLE_CYCLES - 1))) begin
              state[i]     <= LANE_OFF;
              cnt[i]       <= '0;
              clkEn_o[i]   <= 1'b0;
              laneRdy_o[i] <= 1'b0;
            end else begin
              cnt[i]       <= eff_req[i] ? '0 : cnt[i] + CNT_W'(1);
              clkEn_o[i]   <= 1'b1;
              laneRdy_o[i] <= 1'b1;
            end
          end
          default: begin
            state[i]     <= LANE_OFF;
            cnt[i]       <= '0;
            clkEn_o[i]   <= 1'b0;
            laneRdy_o[i] <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl_fg.sv
// Directed bench for clk_gate_ctrl_fg (4 lanes, WAKE_CYCLES=2, IDLE_CYCLES=8).
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_clk_gate_ctrl_fg;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] lane_req;
  logic [3:0] lane_dis;
  logic       force_on;
  logic [3:0] clk_en;
  logic [3:0] lane_rdy;
  logic       wake_pend;

  int n_checks = 0;
  int n_errors = 0;

  clk_gate_ctrl_fg #(
    .NUM_LANES  (4),
    .WAKE_CYCLES(2),
    .IDLE_CYCLES(8)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .laneReq_i    (lane_req),
    .laneDisable_i(lane_dis),
    .forceOn_i    (force_on),
    .clkEn_o      (clk_en),
    .laneRdy_o    (lane_rdy),
    .wakePending_o(wake_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n  = 1'b0;
    lane_req = 4'b0000;
    lane_dis = 4'b0000;
    force_on = 1'b0;
    tick();
    tick();
    check("rst_en",   32'(clk_en),    32'h0);
    check("rst_rdy",  32'(lane_rdy),  32'h0);
    check("rst_pend", 32'(wake_pend), 32'h0);
    reset_n = 1'b1;

    // Single wake on lane 0, then idle gating with a boundary request pulse
    lane_req = 4'b0001;
    tick();
    check("wake_en_t1",  32'(clk_en),   32'h1);
    check("wake_rdy_t1", 32'(lane_rdy), 32'h0);
    tick();
    check("wake_rdy_t2", 32'(lane_rdy), 32'h0);
    tick();
    check("wake_rdy_t3", 32'(lane_rdy), 32'h1);
    check("wake_en_t3",  32'(clk_en),   32'h1);
    tick();                            // last request was the previous cycle (T)
    lane_req = 4'b0000;                // now in T+1
    for (int k = 2; k <= 8; k++) begin
      tick();
      check("idle_hold", 32'(clk_en), 32'h1);
    end
    lane_req = 4'b0001;                // pulse in T+8
    tick();
    lane_req = 4'b0000;                // T+9: pulse kept lane ON
    check("pulse_keep_en",  32'(clk_en),   32'h1);
    check("pulse_keep_rdy", 32'(lane_rdy), 32'h1);
    for (int k = 10; k <= 16; k++) begin
      tick();
      check("idle_hold2", 32'(clk_en), 32'h1);
    end
    tick();                            // T+17 = pulse + 9
    check("gate_en",  32'(clk_en),   32'h0);
    check("gate_rdy", 32'(lane_rdy), 32'h0);

    // Simultaneous wake from rr_ptr = 0
    do_reset();
    lane_req = 4'b1111;
    tick();
    check("sim_en_1", 32'(clk_en), 32'h1);  check("sim_pend_1", 32'(wake_pend), 32'h1);
    tick();
    check("sim_en_2", 32'(clk_en), 32'h3);  check("sim_pend_2", 32'(wake_pend), 32'h1);
    tick();
    check("sim_en_3", 32'(clk_en), 32'h7);  check("sim_pend_3", 32'(wake_pend), 32'h1);
    tick();
    check("sim_en_4", 32'(clk_en), 32'hf);  check("sim_pend_4", 32'(wake_pend), 32'h0);
    lane_req = 4'b0000;

    // Round-robin fairness: grant lane 1 to move rr_ptr to 2
    do_reset();
    lane_req = 4'b0010;
    tick();
    check("rr_setup", 32'(clk_en), 32'h2);
    lane_req = 4'b1011;
    tick();
    check("rr_first",  32'(clk_en),    32'ha);
    check("rr_pend",   32'(wake_pend), 32'h1);
    tick();
    check("rr_second", 32'(clk_en),    32'hb);
    lane_dis = 4'b1111;
    tick();
    check("rr_dis_all", 32'(clk_en),   32'h0);
    check("rr_dis_rdy", 32'(lane_rdy), 32'h0);
    lane_dis = 4'b0000;
    lane_req = 4'b0011;                // rr_ptr should now be 1
    tick();
    check("rr_ptr1_a", 32'(clk_en), 32'h2);
    tick();
    check("rr_ptr1_b", 32'(clk_en), 32'h3);
    lane_req = 4'b0000;

    // Force with lane 2 disabled, then disable lane 1 while ON
    do_reset();
    lane_dis = 4'b0100;
    force_on = 1'b1;
    tick();
    check("force_en_1", 32'(clk_en), 32'h1);
    for (int k = 2; k <= 5; k++) tick();
    check("force_en", 32'(clk_en),   32'hb);
    check("force_rdy", 32'(lane_rdy), 32'hb);
    check("force_pend", 32'(wake_pend), 32'h0);
    lane_dis = 4'b0110;
    tick();                            // D+1
    check("dis_on_en",  32'(clk_en),   32'h9);
    check("dis_on_rdy", 32'(lane_rdy), 32'h9);
    force_on = 1'b0;
    lane_dis = 4'b0100;
    for (int k = 2; k <= 8; k++) tick();
    check("unforce_hold", 32'(clk_en), 32'h9);
    tick();                            // D+9
    check("unforce_gate", 32'(clk_en), 32'h0);
    lane_dis = 4'b0000;

    // Reset mid-wake, then full restart (lane 0 wins only if rr_ptr was cleared)
    lane_req = 4'b0001;
    tick();
    check("mw_en", 32'(clk_en), 32'h1);
    reset_n  = 1'b0;
    lane_req = 4'b0000;
    tick();
    check("mw_rst_en",   32'(clk_en),    32'h0);
    check("mw_rst_rdy",  32'(lane_rdy),  32'h0);
    check("mw_rst_pend", 32'(wake_pend), 32'h0);
    reset_n  = 1'b1;
    lane_req = 4'b0011;
    tick();
    check("mw_re_en1",  32'(clk_en),   32'h1);
    check("mw_re_rdy1", 32'(lane_rdy), 32'h0);
    tick();
    check("mw_re_en2",  32'(clk_en),   32'h3);
    check("mw_re_rdy2", 32'(lane_rdy), 32'h0);
    tick();
    check("mw_re_rdy3", 32'(lane_rdy), 32'h1);
    tick();
    check("mw_re_rdy4", 32'(lane_rdy), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
